// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end: the decode-side NOP,
// the default reset vector and the prefetch FIFO entry layout.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'hE1A0_0000;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} words between instruction memory and decode.
// Flush has priority over push and pop; push+pop together is legal even when full.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  fetch_entry_t  i_data,
    output logic [CW-1:0] o_count,
    output fetch_entry_t  o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Qualify push/pop against flush and an empty FIFO.
    always_comb begin
        w_push = i_push && !i_flush;
        w_pop  = i_pop && !i_flush && (r_count != {CW{1'b0}});
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_stage_chk.sv
// Invariant checker for the fetch stage credit scheme: buffered plus
// in-flight fetches may never exceed the prefetch capacity.
module fetch_stage_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input logic          i_clk,
    input logic          i_rst_n,
    input logic [CW-1:0] i_count,
    input logic [CW-1:0] i_outstanding
);

    localparam logic [CW:0] CAPACITY = (CW + 1)'(DEPTH);

    logic [CW:0] w_total;
    assign w_total = {1'b0, i_count} + {1'b0, i_outstanding};

    a_credit_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_total <= CAPACITY);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC ownership, credit-limited in-order requests to
// a variable-latency memory, prefetch buffering and redirect flush with stale-drop.
// Optional feature macro: FETCH_PERF_EN adds the FetchBubbles counter output.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] PCF,
`ifdef FETCH_PERF_EN
    output logic [31:0] FetchBubbles,
`endif
    output logic [31:0] PCPlus8
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1'b1);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_inflight;
    logic [31:0]   w_redirect_pc;
    logic          w_gnt;
    logic          w_push;
    logic          w_pop;
    logic          w_instr_valid;
    logic          w_unused;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    assign w_redirect_pc = word_align(RedirectPC);
    assign w_unused      = ^RedirectPC[1:0];
    assign w_inflight    = {1'b0, w_count} + {1'b0, r_outstanding};

    // Request issue and FIFO handshake decode. Redirect suppresses issue, push and pop.
    always_comb begin
        ImemReq            = Reset && !Redirect && (w_inflight < CREDITS);
        ImemAddr           = r_pc;
        w_gnt              = ImemReq && ImemGnt;
        w_instr_valid      = (w_count != {CW{1'b0}});
        w_pop              = w_instr_valid && InstrReady && !Redirect;
        w_push             = ImemRValid && !Redirect && (r_drop == {CW{1'b0}});
        w_push_entry.instr = ImemRData;
        w_push_entry.pc    = r_rsp_pc;
    end

    // PC, response-address, in-flight and stale-drop bookkeeping.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_pc          <= RESET_VECTOR;
            r_rsp_pc      <= RESET_VECTOR;
            r_outstanding <= {CW{1'b0}};
            r_drop        <= {CW{1'b0}};
        end else begin
            if (w_gnt && !ImemRValid) begin
                r_outstanding <= r_outstanding + ONE;
            end else if (!w_gnt && ImemRValid) begin
                r_outstanding <= r_outstanding - ONE;
            end

            if (Redirect) begin
                // Everything still in flight is stale, except a response landing right now,
                // which is discarded directly.
                r_pc     <= w_redirect_pc;
                r_rsp_pc <= w_redirect_pc;
                r_drop   <= ImemRValid ? (r_outstanding - ONE) : r_outstanding;
            end else begin
                if (w_gnt) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (ImemRValid) begin
                    if (r_drop != {CW{1'b0}}) begin
                        r_drop <= r_drop - ONE;
                    end else begin
                        r_rsp_pc <= r_rsp_pc + 32'd4;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (Reset),
        .i_flush (Redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    // Decode-facing outputs, driven straight from the registered FIFO head.
    always_comb begin
        InstrValid = w_instr_valid;
        if (w_instr_valid) begin
            Instr = w_head.instr;
            PCF   = w_head.pc;
        end else begin
            Instr = NOP_INSTR;
            PCF   = RESET_VECTOR;
        end
        PCPlus8 = PCF + 32'd8;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_bubbles;

    // Saturating count of cycles where decode was ready but starved.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_bubbles <= 32'h0000_0000;
        end else if (InstrReady && !w_instr_valid && (r_bubbles != 32'hFFFF_FFFF)) begin
            r_bubbles <= r_bubbles + 32'd1;
        end
    end

    assign FetchBubbles = r_bubbles;
`endif

    fetch_stage_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .i_clk         (CLK),
        .i_rst_n       (Reset),
        .i_count       (w_count),
        .i_outstanding (r_outstanding)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver with a random in-order memory model
// queues every granted fetch as an expected decode entry; a monitor checks pops.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt = 1'b0;
    logic        ImemRValid = 1'b0;
    logic [31:0] ImemRData = 32'h0;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic [31:0] Instr;
    logic [31:0] PCF;
    logic [31:0] PCPlus8;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchBubbles;
`endif

    fetch_stage #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRValid (ImemRValid),
        .ImemRData  (ImemRData),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instr      (Instr),
        .PCF        (PCF),
`ifdef FETCH_PERF_EN
        .FetchBubbles (FetchBubbles),
`endif
        .PCPlus8    (PCPlus8)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    pend_t       pend[$];
    exp_t        sb[$];
    int          epoch = 0;
    int          buffered = 0;
    int          cyc = 0;
    int          grants = 0;
    int          pops_seen = 0;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] bub_model = 32'h0;
    int          lat = 1;
    int          p_gnt = 100;
    int          p_rv = 100;
    int          p_ready = 100;
    int          p_redirect = 0;
    bit          req_redirect = 1'b0;
    bit          want_redir3 = 1'b0;
    bit          want_coinc = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    bit          prev_reset = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted decode transfer must match the oldest expected fetch.
    always @(negedge CLK) begin
        exp_t e;
        #3;
        if (Reset && (InstrValid === 1'b1) && InstrReady && !Redirect) begin
            pops_seen++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got PCF %h, expected no entry", PCF);
            end else begin
                e = sb.pop_front();
                chk("pop_pcf", PCF, e.pc);
                chk("pop_instr", Instr, e.instr);
                chk("pop_pcplus8", PCPlus8, e.pc + 32'd8);
            end
        end
    end

    task automatic do_cycle(input bit rst);
        logic  rv;
        logic  exp_req;
        logic  exp_valid;
        pend_t pe;
        int    l;
        @(negedge CLK);
        Reset      = rst;
        rv         = rst && (pend.size() > 0) && (pend[0].due <= cyc) &&
                     ($urandom_range(0, 99) < p_rv);
        Redirect   = 1'b0;
        RedirectPC = $urandom;
        InstrReady = ($urandom_range(0, 99) < p_ready);
        ImemGnt    = ($urandom_range(0, 99) < p_gnt);
        if (rst) begin
            if (want_redir3 && pend.size() >= 3) begin
                rv = 1'b0;
                Redirect = 1'b1;
                RedirectPC = redirect_target;
                want_redir3 = 1'b0;
            end else if (want_coinc && rv && (InstrValid === 1'b1)) begin
                InstrReady = 1'b1;
                Redirect = 1'b1;
                RedirectPC = redirect_target;
                want_coinc = 1'b0;
            end else if (req_redirect) begin
                Redirect = 1'b1;
                RedirectPC = redirect_target;
                req_redirect = 1'b0;
            end else if ($urandom_range(0, 99) < p_redirect) begin
                Redirect = 1'b1;
            end
        end
        ImemRValid = rv;
        ImemRData  = rv ? mem_fn(pend[0].addr) : $urandom;
        #4;
        exp_valid = (buffered != 0);
        if (!rst) begin
            chk("reset_imem_req", 32'(ImemReq), 32'd0);
            if (!prev_reset) begin
                chk("reset_instr_valid", 32'(InstrValid), 32'd0);
                chk("reset_instr", Instr, NOP_INSTR);
                chk("reset_pcf", PCF, 32'h0);
            end
        end else begin
            exp_req = !Redirect && ((pend.size() + buffered) < DEPTH);
            chk("imem_req", 32'(ImemReq), 32'(exp_req));
            if (exp_req) chk("imem_addr", ImemAddr, model_pc);
            chk("instr_valid", 32'(InstrValid), 32'(exp_valid));
            if (!exp_valid) chk("instr_nop", Instr, NOP_INSTR);
        end
`ifdef FETCH_PERF_EN
        if (rst || !prev_reset) chk("fetch_bubbles", FetchBubbles, bub_model);
`endif
        if (!rst) begin
            pend.delete();
            sb.delete();
            buffered  = 0;
            model_pc  = 32'h0;
            bub_model = 32'h0;
            epoch++;
        end else begin
            if (rv) begin
                pe = pend.pop_front();
                if (!Redirect && pe.ep == epoch) buffered++;
            end
            if (ImemReq && ImemGnt) begin
                l = (lat == 0) ? $urandom_range(1, 4) : lat;
                pend.push_back('{ImemAddr, epoch, cyc + l});
                sb.push_back('{model_pc, mem_fn(model_pc)});
                model_pc = model_pc + 32'd4;
                grants++;
            end
            if (exp_valid && InstrReady && !Redirect) buffered--;
            if (InstrReady && !exp_valid && bub_model != 32'hFFFF_FFFF) bub_model = bub_model + 32'd1;
            if (Redirect) begin
                epoch++;
                buffered = 0;
                sb.delete();
                model_pc = {RedirectPC[31:2], 2'b00};
            end
        end
        prev_reset = rst;
        cyc++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int snap;
        // Reset for two cycles, then stream with a 1-cycle memory.
        do_cycle(1'b0);
        do_cycle(1'b0);
        for (int i = 0; i < 10; i++) do_cycle(1'b1);
        snap = pops_seen;
        for (int i = 0; i < 20; i++) do_cycle(1'b1);
        chk("throughput", 32'(pops_seen - snap), 32'd20);

        // Decode stalled: credits cap the grants at DEPTH.
        do_cycle(1'b0);
        p_ready = 0;
        snap = grants;
        for (int i = 0; i < 12; i++) do_cycle(1'b1);
        chk("stall_grants", 32'(grants - snap), 32'd4);
        p_ready = 100;
        for (int i = 0; i < 15; i++) do_cycle(1'b1);

        // 3-cycle memory, redirect with 3 in flight.
        lat = 3;
        redirect_target = 32'h0000_0100;
        want_redir3 = 1'b1;
        for (int i = 0; i < 30; i++) do_cycle(1'b1);
        chk("redir3_fired", 32'(want_redir3), 32'd0);

        // Redirect to an unaligned target, coincident with a response and a pop.
        lat = 1;
        redirect_target = 32'h0000_0103;
        want_coinc = 1'b1;
        for (int i = 0; i < 20; i++) do_cycle(1'b1);
        chk("coinc_fired", 32'(want_coinc), 32'd0);

        // Address wrap at the top of the address space.
        redirect_target = 32'hFFFF_FFF4;
        req_redirect = 1'b1;
        for (int i = 0; i < 20; i++) do_cycle(1'b1);

        // Random traffic with random latency, stalls, redirects and resets.
        lat = 0; p_gnt = 70; p_rv = 70; p_ready = 60; p_redirect = 3;
        for (int i = 0; i < 3000; i++) do_cycle($urandom_range(0, 299) != 0);

        // Drain: stop granting and let everything in flight land and pop.
        p_gnt = 0; p_rv = 100; p_ready = 100; p_redirect = 0;
        for (int i = 0; i < 200 && (pend.size() != 0 || buffered != 0); i++) do_cycle(1'b1);
        chk("drain_done", 32'(pend.size() + buffered), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
